dmem_arbiter: RTL

- Shares the GPP's single-port data memory between two requesters: the GPP datapath (load/store) and the communications processor receive path, which writes received words into data memory.
- Receive-path writes are buffered in a small FIFO and drained into RAM on cycles the GPP leaves idle.
- The GPP is stalled only when the FIFO is full, a pending write is starved, or a GPP access hits a pending address.
- Sits between gpp, the data memory and the comms processor RX RAM interface.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_wr_fifo.sv | 86 ++++++++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 4;

    // Which requester owns the RAM port this cycle
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_GPP,
        GNT_CP
    } grant_e;

    // Pending comms write record at the default widths
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/dmem_wr_fifo.sv
// Pending comms-write FIFO with a per-slot address comparator so the
// arbiter can spot GPP accesses that collide with queued writes.
module dmem_wr_fifo #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          match_addr,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH-1:0]           match
);

    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (level_reg == FULL_LVL);
    assign empty     = (level_reg == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign level     = level_reg;
    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    // Entry storage; contents are meaningless until the slot is marked valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Per-slot valid flag and address comparator for hazard detection
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic slot_valid_reg;

        // Set on push into this slot, cleared when the head pops from it
        always_ff @(posedge clk) begin
            if (rst) begin
                slot_valid_reg <= 1'b0;
            end else if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
                slot_valid_reg <= 1'b1;
            end else if (pop_ok && rd_ptr_reg == PTR_W'(gi)) begin
                slot_valid_reg <= 1'b0;
            end
        end

        assign match[gi] = slot_valid_reg && (addr_mem[gi] == match_addr);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: GPP load/store has priority, comms
// receive writes are queued and drained on idle cycles, with forced drains
// on full FIFO, starvation, or an address collision with a pending write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            gpp_req,
    input  logic                            gpp_we,
    input  logic [ADDR_W-1:0]               gpp_addr,
    input  logic [DATA_W-1:0]               gpp_wdata,
    output logic [DATA_W-1:0]               gpp_rdata,
    output logic                            gpp_stall,
    input  logic                            cp_wr_valid,
    input  logic [ADDR_W-1:0]               cp_wr_addr,
    input  logic [DATA_W-1:0]               cp_wr_data,
    output logic                            cp_wr_ready,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic                            mem_we,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT+1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;
    logic [FIFO_DEPTH-1:0] match_vec;
    logic                  hazard;
    logic                  force_drain;
    logic                  push;
    logic                  pop;
    grant_e                grant;
    logic [CNT_W-1:0]      starve_cnt_reg;
    logic                  overflow_reg;

    assign cp_wr_ready  = !fifo_full;
    assign push         = cp_wr_valid && !fifo_full;
    assign pop          = (grant == GNT_CP) && !rst;
    assign gpp_rdata    = mem_rdata;
    assign overflow_err = overflow_reg;
    assign hazard       = gpp_req && (|match_vec);
    assign force_drain  = !fifo_empty &&
                          (fifo_full || (starve_cnt_reg == STARVE_MAX) || hazard);

    dmem_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (cp_wr_addr),
        .push_data  (cp_wr_data),
        .pop        (pop),
        .match_addr (gpp_addr),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .level      (fifo_level),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .match      (match_vec)
    );

    // Grant decision: forced drain beats the GPP, GPP beats idle draining
    always_comb begin
        grant = GNT_NONE;
        if (force_drain && gpp_req) begin
            grant = GNT_CP;
        end else if (gpp_req) begin
            grant = GNT_GPP;
        end else if (!fifo_empty) begin
            grant = GNT_CP;
        end
    end

    // RAM port steering; the address idles on the GPP address for a fast read path
    always_comb begin
        mem_addr  = gpp_addr;
        mem_wdata = gpp_wdata;
        mem_we    = 1'b0;
        gpp_stall = 1'b0;
        unique case (grant)
            GNT_GPP: mem_we = gpp_we;
            GNT_CP: begin
                mem_addr  = head_addr;
                mem_wdata = head_data;
                mem_we    = 1'b1;
                gpp_stall = gpp_req;
            end
            default: ;
        endcase
        // Nothing may reach RAM while reset is discarding queued words
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Count consecutive GPP wins while comms words wait; any drain clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (pop) begin
            starve_cnt_reg <= '0;
        end else if (!fifo_empty && grant == GNT_GPP && starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
        end
    end

    // Sticky flag for words offered while the FIFO was full
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (cp_wr_valid && fifo_full) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule
